// File: rtl/m_layer_source_0.sv
`default_nettype none
// ============================================================================
// Module   : m_layer_source_0
// Purpose  : Single-frame image buffer that streams one pixel per clock to
//            layer 0 with start held high, then flushes and gaps.
//            Optional macro M_LAYER_SOURCE_REPLAY_EN retains the frame for replay.
// Revision : 1.0 - initial release
// ============================================================================
module m_layer_source_0 #(
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int PIX_W     = 8,
    parameter int FLUSH_CYC = 3,
    parameter int GAP_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [PIX_W-1:0] wr_data,
    output logic             wr_ready,
    input  logic             go,
    input  logic             clr,
    output logic             start,
    output logic [PIX_W-1:0] d_out,
    output logic             full,
    output logic             busy,
    output logic             frame_done
);

    localparam int                 c_N     = IMG_W * IMG_H;
    localparam int                 c_PTR_W = $clog2(c_N);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(c_N - 1);
    localparam logic [3:0]         c_FLUSH = 4'(FLUSH_CYC);
    localparam logic [3:0]         c_GAP   = 4'(GAP_CYC);

    typedef enum logic [2:0] {
        S_EMPTY   = 3'd0,
        S_LOADING = 3'd1,
        S_LOADED  = 3'd2,
        S_STREAM  = 3'd3,
        S_FLUSH   = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    logic [PIX_W-1:0]   r_mem [0:c_N-1];
    state_t             r_state, w_state_nx;
    logic [c_PTR_W-1:0] r_wr_ptr, w_wr_ptr_nx;
    logic [c_PTR_W-1:0] r_rd_ptr, w_rd_ptr_nx;
    logic [c_PTR_W-1:0] w_rd_addr;
    logic [3:0]         r_cnt, w_cnt_nx;
    logic               r_start, w_start_nx;
    logic [PIX_W-1:0]   r_d_out, w_d_out_nx;
    logic               r_full, w_full_nx;
    logic               r_busy, w_busy_nx;
    logic               r_frame_done, w_frame_done_nx;
    logic               r_wr_ready, w_wr_ready_nx;
    logic               w_mem_we;

    always_comb begin
        w_state_nx      = r_state;
        w_wr_ptr_nx     = r_wr_ptr;
        w_rd_ptr_nx     = r_rd_ptr;
        w_cnt_nx        = r_cnt;
        w_start_nx      = 1'b0;
        w_d_out_nx      = '0;
        w_full_nx       = r_full;
        w_busy_nx       = r_busy;
        w_frame_done_nx = 1'b0;
        w_wr_ready_nx   = r_wr_ready;
        w_mem_we        = 1'b0;
        w_rd_addr       = r_rd_ptr + c_PTR_W'(1);

        case (r_state)
            S_EMPTY, S_LOADING: begin
                if (wr_en) begin
                    w_mem_we    = 1'b1;
                    w_wr_ptr_nx = r_wr_ptr + c_PTR_W'(1);
                    if (r_wr_ptr == c_LAST) begin
                        w_state_nx    = S_LOADED;
                        w_full_nx     = 1'b1;
                        w_wr_ready_nx = 1'b0;
                    end else begin
                        w_state_nx = S_LOADING;
                    end
                end
            end
            S_LOADED: begin
                if (go) begin
                    w_rd_addr   = '0;
                    w_state_nx  = S_STREAM;
                    w_start_nx  = 1'b1;
                    w_d_out_nx  = r_mem[w_rd_addr];
                    w_rd_ptr_nx = '0;
                    w_busy_nx   = 1'b1;
                end
            end
            S_STREAM: begin
                if (r_rd_ptr == c_LAST) begin
                    // Last pixel already on the bus: drain the kernel tail or go straight to the gap
                    if (c_FLUSH == 4'd0) begin
                        w_state_nx      = S_GAP;
                        w_cnt_nx        = 4'd1;
                        w_frame_done_nx = (c_GAP == 4'd1);
                    end else begin
                        w_state_nx = S_FLUSH;
                        w_cnt_nx   = 4'd1;
                        w_start_nx = 1'b1;
                    end
                end else begin
                    w_start_nx  = 1'b1;
                    w_d_out_nx  = r_mem[w_rd_addr];
                    w_rd_ptr_nx = w_rd_addr;
                end
            end
            S_FLUSH: begin
                if (r_cnt == c_FLUSH) begin
                    w_state_nx      = S_GAP;
                    w_cnt_nx        = 4'd1;
                    w_frame_done_nx = (c_GAP == 4'd1);
                end else begin
                    w_start_nx = 1'b1;
                    w_cnt_nx   = r_cnt + 4'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == c_GAP) begin
                    w_busy_nx = 1'b0;
`ifdef M_LAYER_SOURCE_REPLAY_EN
                    w_state_nx = S_LOADED;
`else
                    w_state_nx    = S_EMPTY;
                    w_full_nx     = 1'b0;
                    w_wr_ready_nx = 1'b1;
                    w_wr_ptr_nx   = '0;
`endif
                end else begin
                    w_cnt_nx        = r_cnt + 4'd1;
                    w_frame_done_nx = ((r_cnt + 4'd1) == c_GAP);
                end
            end
            default: w_state_nx = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state      <= S_EMPTY;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= 4'd0;
            r_start      <= 1'b0;
            r_d_out      <= '0;
            r_full       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_wr_ready   <= 1'b1;
        end else begin
            r_state      <= w_state_nx;
            r_wr_ptr     <= w_wr_ptr_nx;
            r_rd_ptr     <= w_rd_ptr_nx;
            r_cnt        <= w_cnt_nx;
            r_start      <= w_start_nx;
            r_d_out      <= w_d_out_nx;
            r_full       <= w_full_nx;
            r_busy       <= w_busy_nx;
            r_frame_done <= w_frame_done_nx;
            r_wr_ready   <= w_wr_ready_nx;
        end
    end

    // Buffer contents are don't-care after reset, so the array carries no reset
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst && !clr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign start      = r_start;
    assign d_out      = r_d_out;
    assign full       = r_full;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign wr_ready   = r_wr_ready;

endmodule
`default_nettype wire

// File: tb/tb_m_layer_source_0.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_layer_source_0
// Purpose  : Self-checking bench; instance A uses default timing, instance B
//            uses FLUSH_CYC=0 / GAP_CYC=4. sel routes stimulus and observation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_layer_source_0;

    localparam int c_N = 784;

    logic       clk = 1'b0;
    logic       rst, wr_en, go, clr, sel;
    logic [7:0] wr_data;

    logic       a_wr_ready, a_start, a_full, a_busy, a_frame_done;
    logic [7:0] a_d_out;
    logic       b_wr_ready, b_start, b_full, b_busy, b_frame_done;
    logic [7:0] b_d_out;

    logic       m_wr_ready, m_start, m_full, m_busy, m_frame_done;
    logic [7:0] m_d_out;

    assign m_wr_ready   = sel ? b_wr_ready   : a_wr_ready;
    assign m_start      = sel ? b_start      : a_start;
    assign m_full       = sel ? b_full       : a_full;
    assign m_busy       = sel ? b_busy       : a_busy;
    assign m_frame_done = sel ? b_frame_done : a_frame_done;
    assign m_d_out      = sel ? b_d_out      : a_d_out;

    m_layer_source_0 dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en & ~sel), .wr_data(wr_data), .wr_ready(a_wr_ready),
        .go(go & ~sel), .clr(clr & ~sel),
        .start(a_start), .d_out(a_d_out), .full(a_full),
        .busy(a_busy), .frame_done(a_frame_done)
    );

    m_layer_source_0 #(.FLUSH_CYC(0), .GAP_CYC(4)) dut_b (
        .clk(clk), .rst(rst),
        .wr_en(wr_en & sel), .wr_data(wr_data), .wr_ready(b_wr_ready),
        .go(go & sel), .clr(clr & sel),
        .start(b_start), .d_out(b_d_out), .full(b_full),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model [0:c_N-1];
    logic [7:0] sb [$];

    typedef struct {
        logic       wr_en;
        logic       go;
        logic       clr;
        logic [7:0] data;
        logic       e_start;
        logic       e_busy;
        logic       e_full;
        logic       e_wr_ready;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " start"}, 32'(m_start), 0);
        chk({tag, " d_out"}, 32'(m_d_out), 0);
        chk({tag, " frame_done"}, 32'(m_frame_done), 0);
        chk({tag, " busy"}, 32'(m_busy), 0);
        chk({tag, " full"}, 32'(m_full), 0);
        chk({tag, " wr_ready"}, 32'(m_wr_ready), 1);
    endtask

    function automatic logic [7:0] pix(input int i, input int seed);
        return (seed == 0) ? 8'(i) : 8'(i * 7 + seed * 13);
    endfunction

    task automatic load(input int first, input int last, input int seed);
        for (int i = first; i <= last; i++) begin
            wr_en   = 1'b1;
            wr_data = pix(i, seed);
            model[i] = wr_data;
            tick();
        end
        wr_en = 1'b0;
    endtask

    // Expected stream is queued at the moment go is driven
    task automatic pulse_go();
        for (int i = 0; i < c_N; i++) sb.push_back(model[i]);
        if (!sel) repeat (3) sb.push_back(8'h00);
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic check_high(input int n);
        for (int i = 0; i < n; i++) begin
            chk("stream start", 32'(m_start), 1);
            chk("stream busy", 32'(m_busy), 1);
            if (sb.size() == 0) chk("scoreboard underflow", 32'(m_d_out), 32'hFFFF_FFFF);
            else chk("stream d_out", 32'(m_d_out), 32'(sb.pop_front()));
            tick();
        end
    endtask

    task automatic check_frame(input int exp_hi, input int exp_lo);
        int hi = 0;
        while (m_start && hi < exp_hi + 8) begin
            if (sb.size() == 0) chk("scoreboard underflow", 32'(m_d_out), 32'hFFFF_FFFF);
            else chk("stream d_out", 32'(m_d_out), 32'(sb.pop_front()));
            hi++;
            tick();
        end
        chk("start high cycles", 32'(hi), 32'(exp_hi));
        chk("scoreboard empty", 32'(sb.size()), 0);
        sb.delete();
        for (int i = 0; i < exp_lo; i++) begin
            chk("gap start", 32'(m_start), 0);
            chk("gap d_out", 32'(m_d_out), 0);
            chk("gap busy", 32'(m_busy), 1);
            chk("gap frame_done", 32'(m_frame_done), (i == exp_lo - 1) ? 1 : 0);
            tick();
        end
        chk("post frame_done", 32'(m_frame_done), 0);
        chk("post busy", 32'(m_busy), 0);
        chk("post start", 32'(m_start), 0);
`ifdef M_LAYER_SOURCE_REPLAY_EN
        chk("post full", 32'(m_full), 1);
        chk("post wr_ready", 32'(m_wr_ready), 0);
`else
        chk("post full", 32'(m_full), 0);
        chk("post wr_ready", 32'(m_wr_ready), 1);
`endif
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        vec_t vecs [5];
        vecs[0] = '{wr_en:1'b0, go:1'b1, clr:1'b0, data:8'h00, e_start:1'b0, e_busy:1'b0, e_full:1'b0, e_wr_ready:1'b1};
        vecs[1] = '{wr_en:1'b1, go:1'b1, clr:1'b0, data:8'h11, e_start:1'b0, e_busy:1'b0, e_full:1'b0, e_wr_ready:1'b1};
        vecs[2] = '{wr_en:1'b1, go:1'b0, clr:1'b1, data:8'h22, e_start:1'b0, e_busy:1'b0, e_full:1'b0, e_wr_ready:1'b1};
        vecs[3] = '{wr_en:1'b0, go:1'b1, clr:1'b0, data:8'h00, e_start:1'b0, e_busy:1'b0, e_full:1'b0, e_wr_ready:1'b1};
        vecs[4] = '{wr_en:1'b0, go:1'b0, clr:1'b0, data:8'h00, e_start:1'b0, e_busy:1'b0, e_full:1'b0, e_wr_ready:1'b1};

        rst = 1'b1; wr_en = 1'b0; go = 1'b0; clr = 1'b0; sel = 1'b0; wr_data = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");

        // Commands in EMPTY/LOADING that must not start a stream
        for (int i = 0; i < 5; i++) begin
            wr_en = vecs[i].wr_en; go = vecs[i].go; clr = vecs[i].clr; wr_data = vecs[i].data;
            tick();
            chk($sformatf("vec%0d start", i), 32'(m_start), 32'(vecs[i].e_start));
            chk($sformatf("vec%0d busy", i), 32'(m_busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d full", i), 32'(m_full), 32'(vecs[i].e_full));
            chk($sformatf("vec%0d wr_ready", i), 32'(m_wr_ready), 32'(vecs[i].e_wr_ready));
        end
        wr_en = 1'b0; go = 1'b0; clr = 1'b0;

        // Load, stream and timing
        load(0, c_N - 1, 0);
        chk("loaded full", 32'(m_full), 1);
        chk("loaded wr_ready", 32'(m_wr_ready), 0);
        chk("loaded start", 32'(m_start), 0);
        pulse_go();
        chk("first pixel d_out", 32'(m_d_out), 0);
        check_frame(787, 1);

`ifdef M_LAYER_SOURCE_REPLAY_EN
        pulse_go();
        check_frame(787, 1);
        pulse_clr();
        chk("replay clr full", 32'(m_full), 0);
        chk("replay clr wr_ready", 32'(m_wr_ready), 1);
`endif
        pulse_clr();

        // Backpressure and ignored commands
        load(0, 499, 1);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("early go start", 32'(m_start), 0);
        chk("early go busy", 32'(m_busy), 0);
        chk("early go full", 32'(m_full), 0);
        load(500, c_N - 2, 1);
        wr_en = 1'b1; go = 1'b1; wr_data = pix(c_N - 1, 1); model[c_N - 1] = wr_data;
        tick();
        go = 1'b0; wr_data = 8'hAA;
        chk("final write go start", 32'(m_start), 0);
        chk("final write full", 32'(m_full), 1);
        tick();
        chk("extra write full", 32'(m_full), 1);
        chk("extra write wr_ready", 32'(m_wr_ready), 0);
        chk("go not queued", 32'(m_start), 0);
        wr_data = 8'h55;
        pulse_go();
        check_frame(787, 1);
        wr_en = 1'b0;

        // Abort mid-stream
        pulse_clr();
        load(0, c_N - 1, 2);
        pulse_go();
        check_high(300);
        pulse_clr();
        sb.delete();
        chk_idle("abort");
        for (int i = 0; i < 6; i++) begin
            chk("abort no frame_done", 32'(m_frame_done), 0);
            chk("abort no start", 32'(m_start), 0);
            tick();
        end
        load(0, c_N - 1, 3);
        pulse_go();
        check_frame(787, 1);

        // Reset while flushing
        pulse_clr();
        load(0, c_N - 1, 4);
        pulse_go();
        check_high(c_N);
        chk("in flush start", 32'(m_start), 1);
        chk("in flush d_out", 32'(m_d_out), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk_idle("flush rst");
        go = 1'b1;
        tick();
        go = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post rst go start", 32'(m_start), 0);
            chk("post rst go busy", 32'(m_busy), 0);
            tick();
        end
        load(0, c_N - 1, 5);
        pulse_go();
        check_frame(787, 1);

        // FLUSH_CYC=0, GAP_CYC=4 instance
        sel = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("b reset");
        load(0, c_N - 1, 6);
        pulse_go();
        check_frame(784, 4);
        sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m_layer_source_0.md
Name: m_layer_source_0

Overview:
- Frame transmitter that feeds the convolution input layer (m_layer_input_0 protocol).
- Buffers one IMG_W x IMG_H 8-bit image written sequentially by the host.
- On command, streams the image one pixel per clock with `start` held high for the whole frame, then drops `start` so the downstream pixel counter clears.
- Sits between the host/test loader and layer 0.

Parameters:
- IMG_W, 28, image width in pixels
- IMG_H, 28, image height in pixels
- PIX_W, 8, pixel width in bits
- FLUSH_CYC, 3, cycles `start` stays high after the last pixel, with d_out=0 (kernel tail drain); legal range 0..15
- GAP_CYC, 1, cycles `start` is held low between frames; legal range 1..15

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  host pixel write strobe
- wr_data  in  PIX_W  host pixel; raster order, row-major, address auto-increments
- wr_ready  out  1  buffer accepts a write this cycle
- go  in  1  request to stream the buffered frame
- clr  in  1  abort any activity and empty the buffer
- start  out  1  frame-active strobe to layer 0
- d_out  out  PIX_W  pixel to layer 0
- full  out  1  complete frame buffered
- busy  out  1  streaming, flushing or in gap
- frame_done  out  1  one-cycle pulse at end of gap

Behaviour:
- Reset and clr values: start=0, d_out=0, frame_done=0, busy=0, full=0, wr_ready=1, state=EMPTY, wr_ptr=0, rd_ptr=0. Buffer contents are don't-care.
- N = IMG_W*IMG_H = 784. Pointer width is clog2(N) = 10. All outputs are registered.
- States are EMPTY, LOADING, LOADED, STREAM, FLUSH, GAP.
- EMPTY / LOADING:
  - wr_ready=1; wr_en writes mem[wr_ptr] and increments wr_ptr.
  - The first write moves EMPTY to LOADING.
  - The write that makes wr_ptr reach N moves to LOADED. In the following cycle full=1 and wr_ready=0.
- LOADED:
  - wr_en is ignored.
  - go=1 moves to STREAM. go in any other state is ignored and not queued.
- STREAM:
  - On the cycle after go is accepted, start=1 and d_out=mem[0].
  - Pixel k appears exactly k+1 cycles after go; there are no bubbles.
  - busy=1 from the same cycle as the first start=1.
- FLUSH:
  - Entered after pixel N-1 has been presented.
  - start=1, d_out=0 for FLUSH_CYC cycles. If FLUSH_CYC=0, go directly to GAP.
- GAP:
  - start=0, d_out=0 for GAP_CYC cycles.
  - frame_done=1 in the last GAP cycle.
  - Next state is EMPTY: full=0, wr_ptr=0, wr_ready=1, busy=0 on the cycle after frame_done.
- Total start-high window = N+FLUSH_CYC cycles. Downstream layer_0_ready therefore rises at pixel 87 (3*IMG_W+3) and stays high through flush.
- Priority: rst > clr > go/wr_en.
  - clr mid-stream drops start on the next edge, with no flush, no gap counting and no frame_done.
  - clr together with go: clr wins.
  - wr_en with wr_ready=0 is dropped silently; the pointer does not move.
  - go on the same cycle as the final write is ignored, because the block is not yet LOADED.
- Next frame may be loaded only after returning to EMPTY. Writes during STREAM, FLUSH or GAP are dropped.

Optional Feature:
- Macro M_LAYER_SOURCE_REPLAY_EN.
- Defined:
  - GAP exits to LOADED instead of EMPTY; full stays 1 and the buffer is retained.
  - A new go replays the identical frame.
  - Only clr (or rst) empties the buffer for a new image.
- Undefined: the buffer is consumed each frame and GAP always exits to EMPTY as described above.

Test Plan:
- Load, stream, timing:
  - Stimulus: rst 2 cycles; write 784 pixels with value = addr[7:0]; pulse go.
  - Required: start high for 787 cycles; d_out sequence 0,1,...,255,0,...,15 then three 0s; start low for 1 cycle; frame_done pulse; wr_ready=1 on the next cycle.
- Backpressure and ignored commands:
  - Stimulus: go pulsed at 500 pixels written; wr_en on the 785th write and during STREAM.
  - Required: no streaming before full; extra writes dropped; frame content unchanged.
- Abort:
  - Stimulus: clr at pixel 300 of stream.
  - Required: start=0 next cycle; no frame_done; full=0; a fresh 784-pixel load and go stream correctly from mem[0].
- Reset mid-operation:
  - Stimulus: rst during FLUSH.
  - Required: all outputs at reset values on the next edge; a subsequent go is ignored until a full load.
- Parameter corners:
  - Stimulus: FLUSH_CYC=0, GAP_CYC=4.
  - Required: start high exactly 784 cycles, low 4 cycles, frame_done in the 4th low cycle.
- Replay (M_LAYER_SOURCE_REPLAY_EN defined):
  - Stimulus: go twice after one load.
  - Required: two identical 787-cycle frames separated by the gap; full stays 1 until clr.
